sine_phase_nco: RTL and testbench



---
 rtl/sine_phase_nco.sv | 93 +++++++++
 tb/tb_sine_phase_nco.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/sine_phase_nco.sv
// sine_phase_nco: phase accumulator driving the sine ROM index, with click-free note release.
// Define SINE_NCO_GLIDE_EN for portamento (step slews toward the target frequency).
module sine_phase_nco #(
    parameter int unsigned TABLE_LEN = 48000,
    parameter int unsigned FRAC_W    = 8,
    parameter int unsigned MAX_STEP  = 24000
`ifdef SINE_NCO_GLIDE_EN
    ,
    parameter int unsigned GLIDE_RATE = 16
`endif
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                advance,
    input  logic [14+FRAC_W:0]  freq,
    input  logic                note_on,
    input  logic                note_off,
    output logic [16:0]         x_val,
    output logic                out_valid,
    output logic                active
);
    localparam int unsigned PW = 17 + FRAC_W;
    localparam int unsigned SW = 15 + FRAC_W;
    localparam logic [PW-1:0] LIMIT = PW'(64'(TABLE_LEN) << FRAC_W);
    localparam logic [SW-1:0] CLAMP = SW'(64'(MAX_STEP) << FRAC_W);
    localparam logic [16:0]   HALF  = 17'(TABLE_LEN / 2);
    typedef enum logic [1:0] {IDLE, RUN, RELEASE} state_t;
    state_t state, state_nx;
    logic [PW-1:0] phase, nphase;
    logic [SW-1:0] step, eff, step_adv, step_on;
    logic [PW:0]   sum;
    logic [16:0]   xi, ni;
    logic          wrap, hit, pend, live, stop0;
    always_comb begin
        eff = freq > CLAMP ? CLAMP : freq;
`ifdef SINE_NCO_GLIDE_EN
        step_adv = step < eff ? ((eff - step) > SW'(GLIDE_RATE) ? step + SW'(GLIDE_RATE) : eff)
                              : ((step - eff) > SW'(GLIDE_RATE) ? step - SW'(GLIDE_RATE) : eff);
        step_on  = state == IDLE ? eff : step;
`else
        step_adv = eff;
        step_on  = eff;
`endif
        sum    = (PW+1)'(phase) + (PW+1)'(step_adv);
        wrap   = sum >= (PW+1)'(LIMIT);
        nphase = wrap ? PW'(sum - (PW+1)'(LIMIT)) : PW'(sum);
        xi     = phase[PW-1:FRAC_W];
        ni     = nphase[PW-1:FRAC_W];
        // Stop point for release: landed on or passed a zero crossing of the sine.
        hit    = wrap || ni == '0 || (xi < HALF && ni >= HALF);
        live   = state != IDLE;
        stop0  = live && note_off && step == '0;
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    always_comb begin
        state_nx = note_on                                  ? RUN     :
                   stop0                                    ? IDLE    :
                   state == RUN && note_off                 ? RELEASE :
                   state == RELEASE && advance && hit       ? IDLE    : state;
    end
    always_comb begin
        active = live;
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            phase     <= '0;
            step      <= '0;
            x_val     <= '0;
            pend      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= pend;
            if (note_on) begin
                phase <= '0;
                x_val <= '0;
                step  <= step_on;
                pend  <= 1'b1;
            end else if (stop0) begin
                phase <= '0;
                x_val <= '0;
                pend  <= 1'b0;
            end else if (live && advance) begin
                step  <= step_adv;
                phase <= state == RELEASE && hit ? '0 : nphase;
                x_val <= state == RELEASE && hit ? '0 : ni;
                pend  <= 1'b1;
            end else begin
                pend  <= 1'b0;
            end
        end
endmodule

// File: tb/tb_sine_phase_nco.sv
// tb_sine_phase_nco: directed table plus hand sequences for wrap, clamp, release, priority and reset.
module tb_sine_phase_nco;
    logic        clk = 0, reset_n = 0, advance = 0, note_on = 0, note_off = 0;
    logic [14:0] freq0 = 0;
    logic [22:0] freq8 = 0;
    logic [16:0] x0, x8;
    logic        v0, v8, a0, a8;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    sine_phase_nco #(.FRAC_W(0)) dut0 (.clk(clk), .reset_n(reset_n), .advance(advance), .freq(freq0),
        .note_on(note_on), .note_off(note_off), .x_val(x0), .out_valid(v0), .active(a0));
    sine_phase_nco #(.FRAC_W(8)) dut8 (.clk(clk), .reset_n(reset_n), .advance(advance), .freq(freq8),
        .note_on(note_on), .note_off(note_off), .x_val(x8), .out_valid(v8), .active(a8));
    typedef struct {
        logic on, off, adv;
        int   x;
        logic act, v;
    } vec_t;
    vec_t tbl[16];
    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask
    task automatic cyc(input logic on, input logic off, input logic adv);
        note_on = on; note_off = off; advance = adv;
        @(negedge clk);
        note_on = 0; note_off = 0; advance = 0;
    endtask
    initial begin
        tbl = '{
            '{0,0,0,    0,0,0}, '{1,0,0,    0,1,0}, '{0,0,0,    0,1,1}, '{0,0,1,  440,1,0},
            '{0,0,0,  440,1,1}, '{0,0,0,  440,1,0}, '{0,0,1,  880,1,0}, '{0,0,1, 1320,1,1},
            '{0,0,0, 1320,1,1}, '{1,1,0,    0,1,0}, '{1,0,1,    0,1,1}, '{0,0,0,    0,1,1},
            '{0,1,0,    0,1,0}, '{0,0,1,  440,1,0}, '{0,1,0,  440,1,1}, '{0,0,0,  440,1,0}};
        @(negedge clk);
        chk("reset_x", int'(x0), 0);
        chk("reset_active", int'(a0), 0);
        chk("reset_valid", int'(v0), 0);
        reset_n = 1;
        @(negedge clk);
        freq0 = 440;
        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].on, tbl[i].off, tbl[i].adv);
            chk($sformatf("tbl%0d_x", i), int'(x0), tbl[i].x);
            chk($sformatf("tbl%0d_active", i), int'(a0), int'(tbl[i].act));
            chk($sformatf("tbl%0d_valid", i), int'(v0), int'(tbl[i].v));
        end
        // Release at the half-period crossing
        freq0 = 100;
        cyc(1, 0, 0);
        repeat (238) cyc(0, 0, 1);
        chk("rel_pre_x", int'(x0), 23800);
        freq0 = 440;
        cyc(0, 1, 0);
        chk("rel_active_hold", int'(a0), 1);
        cyc(0, 0, 1);
        chk("rel_x", int'(x0), 0);
        chk("rel_active", int'(a0), 0);
        cyc(0, 0, 0);
        chk("rel_final_valid", int'(v0), 1);
        cyc(0, 0, 1);
        chk("rel_idle_x", int'(x0), 0);
        chk("rel_idle_valid", int'(v0), 0);
        cyc(0, 0, 0);
        chk("rel_idle_valid2", int'(v0), 0);
        // note_off with zero step stops at once
        freq0 = 0;
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        chk("zero_step_off", int'(a0), 0);
        // Table wrap
        freq0 = 500;
        cyc(1, 0, 0);
        repeat (95) cyc(0, 0, 1);
        chk("wrap_pre_x", int'(x0), 47500);
        freq0 = 1000;
        cyc(0, 0, 1);
        chk("wrap_x", int'(x0), 500);
        // Clamp and fractional step
        freq8 = 23'(30000 * 256);
        cyc(1, 0, 0);
        chk("clamp_x0", int'(x8), 0);
        cyc(0, 0, 1);
        chk("clamp_x1", int'(x8), 24000);
        cyc(0, 0, 1);
        chk("clamp_x2", int'(x8), 0);
        cyc(0, 0, 1);
        chk("clamp_x3", int'(x8), 24000);
        freq8 = 23'h80;
        cyc(1, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            cyc(0, 0, 1);
            chk($sformatf("frac_x%0d", i), int'(x8), i / 2);
        end
        // note_on beats note_off
        freq0 = 12345;
        cyc(1, 0, 0);
        cyc(0, 0, 1);
        chk("prio_pre_x", int'(x0), 12345);
        cyc(1, 1, 0);
        chk("prio_x", int'(x0), 0);
        chk("prio_active", int'(a0), 1);
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        chk("prio_run_x", int'(x0), 24690);
        chk("prio_run_active", int'(a0), 1);
`ifdef SINE_NCO_GLIDE_EN
        freq0 = 440;
        cyc(1, 0, 0);
        freq0 = 600;
        for (int k = 1; k <= 11; k++) begin
            int prev;
            prev = int'(x0);
            cyc(0, 0, 1);
            chk($sformatf("glide_step%0d", k), int'(x0) - prev, (440 + 16 * k) > 600 ? 600 : 440 + 16 * k);
        end
`endif
        // Asynchronous reset mid-note
        freq0 = 500;
        cyc(1, 0, 0);
        repeat (10) cyc(0, 0, 1);
        chk("areset_pre_x", int'(x0), 5000);
        @(posedge clk);
        #1;
        chk("areset_pre_valid", int'(v0), 1);
        reset_n = 0;
        #1;
        chk("areset_x", int'(x0), 0);
        chk("areset_active", int'(a0), 0);
        chk("areset_valid", int'(v0), 0);
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
